// File: rtl/mlp_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_acc_pkg
//  Description : Shared state encoding, default widths and the requantize /
//                saturate helper for the MLP neuron accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package mlp_acc_pkg;

  // Default widths and shift for the neuron accumulator
  localparam int C_PROD_WIDTH = 20;
  localparam int C_BIAS_WIDTH = 24;
  localparam int C_ACC_WIDTH  = 32;
  localparam int C_N_INPUTS   = 16;
  localparam int C_SHIFT      = 8;
  localparam int C_OUT_WIDTH  = 16;

  // Widest sum the helper handles; callers sign-extend into this width
  localparam int C_REQ_MAX_W  = 64;

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  // ReLU, truncating right shift, then clip to an out_width-bit unsigned max.
  // Result packs {sat, data}; data is zero-extended to C_REQ_MAX_W bits.
  function automatic logic [C_REQ_MAX_W:0] requant_sat(
    input logic signed [C_REQ_MAX_W-1:0] sum,
    input int                            shift,
    input int                            out_width
  );
    logic [C_REQ_MAX_W-1:0] r;
    logic [C_REQ_MAX_W-1:0] lim;
    logic                   sat;
    r   = sum[C_REQ_MAX_W-1] ? '0 : C_REQ_MAX_W'(sum >> shift);
    lim = (C_REQ_MAX_W'(1) << out_width) - C_REQ_MAX_W'(1);
    sat = 1'b0;
    if (r > lim) begin
      r   = lim;
      sat = 1'b1;
    end
    return {sat, r};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_requant_relu.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_requant_relu
//  Description : Combinational ReLU + right-shift requantization + unsigned
//                saturation of a signed accumulator sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module mlp_requant_relu
  import mlp_acc_pkg::*;
#(
  parameter int ACC_WIDTH = C_ACC_WIDTH,
  parameter int SHIFT     = C_SHIFT,
  parameter int OUT_WIDTH = C_OUT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic        [OUT_WIDTH-1:0] data,
  output logic                        sat
);

  logic [C_REQ_MAX_W:0] w_res;
  logic                 w_unused_hi;

  // Sign-extend into the helper's working width; the clip guarantees that
  // everything above OUT_WIDTH is zero, so only the low slice is kept.
  assign w_res       = requant_sat(C_REQ_MAX_W'(sum), SHIFT, OUT_WIDTH);
  assign data        = w_res[OUT_WIDTH-1:0];
  assign sat         = w_res[C_REQ_MAX_W];
  assign w_unused_hi = ^w_res[C_REQ_MAX_W-1:OUT_WIDTH];

endmodule
`default_nettype wire

// File: rtl/mlp_neuron_acc.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_neuron_acc
//  Description : Accumulates N_INPUTS unsigned products on top of a signed
//                bias, then emits one ReLU/requantized/saturated activation
//                per neuron over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mlp_neuron_acc
  import mlp_acc_pkg::*;
#(
  parameter int PROD_WIDTH = C_PROD_WIDTH,
  parameter int BIAS_WIDTH = C_BIAS_WIDTH,
  parameter int ACC_WIDTH  = C_ACC_WIDTH,
  parameter int N_INPUTS   = C_N_INPUTS,
  parameter int SHIFT      = C_SHIFT,
  parameter int OUT_WIDTH  = C_OUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_prod,
  input  logic [BIAS_WIDTH-1:0] bias_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                  r_out_valid;
  logic [OUT_WIDTH-1:0]  r_out_data;
  logic                  r_out_sat;

  logic                  w_accept;
  logic                  w_out_take;
  logic                  w_last;
  logic signed [ACC_WIDTH-1:0] w_bias_ext;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_base;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic [OUT_WIDTH-1:0]  w_req_data;
  logic                  w_req_sat;

  // in_ready depends only on registered state, never on in_valid/out_ready
  assign in_ready   = (r_state == ST_ACC);
  assign w_accept   = ce & in_valid & in_ready;
  assign w_out_take = ce & out_ready & (r_state == ST_OUT);
  assign w_last     = (r_cnt == CNT_W'(N_INPUTS - 1));

  // The first product of a neuron starts from the bias instead of the
  // stale accumulator, so no explicit clear is needed between neurons.
  assign w_bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bias_in[BIAS_WIDTH-1]}}, bias_in};
  assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, in_prod};
  assign w_base     = (r_cnt == '0) ? w_bias_ext : r_acc;
  assign w_sum      = w_base + w_prod_ext;

  mlp_requant_relu #(
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_requant (
    .sum  (w_sum),
    .data (w_req_data),
    .sat  (w_req_sat)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_ACC;
    else       r_state <= w_next_state;
  end

  // Next-state: leave ACC on the last accepted product, leave OUT on take
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_ACC:  if (w_accept && w_last) w_next_state = ST_OUT;
      ST_OUT:  if (w_out_take)         w_next_state = ST_ACC;
      default: w_next_state = ST_ACC;
    endcase
  end

  // Product counter and running sum, advanced only on accepted products
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Output registers: capture the requantized final sum, hold until taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_accept && w_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_req_data;
      r_out_sat   <= w_req_sat;
    end else if (w_out_take) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_mlp_neuron_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mlp_neuron_acc
//  Description : Scoreboard bench for mlp_neuron_acc (N_INPUTS=4, SHIFT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_neuron_acc;

  localparam int TB_N     = 4;
  localparam int TB_SHIFT = 4;
  localparam int TB_OUTW  = 16;

  typedef struct {
    logic [15:0] data;
    logic        sat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_prod;
  logic [23:0] bias_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mlp_neuron_acc #(
    .N_INPUTS  (TB_N),
    .SHIFT     (TB_SHIFT),
    .OUT_WIDTH (TB_OUTW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .bias_in   (bias_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else             n_pass++;
  endtask

  // Reference: ReLU, truncating shift, clip to 16-bit unsigned
  function automatic exp_t model(input longint s);
    exp_t   e;
    longint r;
    r = (s < 0) ? 64'sd0 : (s >>> TB_SHIFT);
    if (r > 65535) begin
      e.data = 16'hFFFF;
      e.sat  = 1'b1;
    end else begin
      e.data = r[15:0];
      e.sat  = 1'b0;
    end
    return e;
  endfunction

  // Output monitor: every completed output transfer is scored
  always @(negedge clk) begin
    if (!reset && ce && out_valid && out_ready) begin
      check_val("sb_nonempty", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("out_data", out_data, e.data);
        check_val("out_sat", out_sat, e.sat);
      end
    end
  end

  // Present one product and wait (bounded) until it is accepted
  task automatic push_prod(input logic [19:0] p);
    bit ok;
    int guard;
    in_valid = 1'b1;
    in_prod  = p;
    guard    = 0;
    do begin
      @(negedge clk);
      ok = in_ready && ce;
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 100);
    check_val("accept", ok, 1);
  endtask

  task automatic send_neuron(input longint bias, input int p0, input int p1,
                             input int p2, input int p3);
    exp_q.push_back(model(bias + p0 + p1 + p2 + p3));
    bias_in = 24'(bias);
    push_prod(20'(p0));
    push_prod(20'(p1));
    push_prod(20'(p2));
    push_prod(20'(p3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g;
    reset     = 1'b1;
    ce        = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    bias_in   = '0;
    out_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_sat", out_sat, 0);
    check_val("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 reset = 1'b0;

    // 1: basic sum, latency and in_ready recovery
    send_neuron(0, 256, 512, 768, 1024);
    in_valid = 1'b0;
    check_val("lat_out_valid", out_valid, 1);
    check_val("lat_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check_val("rec_in_ready", in_ready, 1);
    check_val("rec_out_valid", out_valid, 0);

    // 2: ReLU clamps a negative sum to zero
    send_neuron(-3000, 256, 512, 768, 1024);
    in_valid = 1'b0;

    // 3: saturation
    send_neuron(0, 1048575, 1048575, 1048575, 1048575);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // 4: back-pressure with a new product waiting
    out_ready = 1'b0;
    send_neuron(0, 256, 512, 768, 1024);
    in_prod = 20'd100;
    repeat (5) begin
      @(negedge clk);
      check_val("bp_out_valid", out_valid, 1);
      check_val("bp_out_data", out_data, 160);
      check_val("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_neuron(0, 100, 200, 300, 400);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // 5: ce stall mid-neuron with in_valid held high
    exp_q.push_back(model(2560));
    bias_in = '0;
    push_prod(20'd256);
    push_prod(20'd512);
    in_prod = 20'd768;
    ce      = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("stall_out_valid", out_valid, 0);
      check_val("stall_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
    end
    ce = 1'b1;
    push_prod(20'd768);
    push_prod(20'd1024);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // 6: reset mid-neuron discards the partial sum
    bias_in = 24'd5000;
    push_prod(20'd256);
    push_prod(20'd512);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_out_data", out_data, 0);
    check_val("mid_rst_out_sat", out_sat, 0);
    check_val("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    send_neuron(0, 256, 512, 768, 1024);
    in_valid = 1'b0;

    // Drain the scoreboard
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    check_val("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
